// File: rtl/key_conditioner.sv
// key_conditioner
//
// Front-end conditioner for the nine raw vending-machine buttons. Each channel
// is synchronised (two flops), debounced with its own counter, and turned into
// a one-clock press pulse on the 0->1 transition of the debounced level.
// Releases are debounced the same way but never pulse.
//
// Optional build macro: KEY_ONEHOT_EN
//   When defined, pulses pass through a 9-bit pending register and are issued
//   one per cycle in fixed priority order:
//   Cancel > Confirm > Goods > Change > fifty > twenty > ten > five > one.
//   This adds one cycle of pulse latency; key_level timing is unchanged.
//
// Ports:
//   sys_clk          in   system clock (rising edge)
//   sys_rst          in   synchronous active-high reset
//   key_raw[8:0]     in   asynchronous button levels, 1 = pressed
//                         [0] Goods [1] Confirm [2] Change [3] Cancel
//                         [4] one [5] five [6] ten [7] twenty [8] fifty
//   sys_Goods/Confirm/Change/Cancel   out  function-key press pulses
//   in_money_one/five/ten/twenty/fifty out money-key press pulses
//   key_level[8:0]   out  debounced stable level, same bit map as key_raw
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [8:0] key_raw,
  output logic       sys_Goods,
  output logic       sys_Confirm,
  output logic       sys_Change,
  output logic       sys_Cancel,
  output logic       in_money_one,
  output logic       in_money_five,
  output logic       in_money_ten,
  output logic       in_money_twenty,
  output logic       in_money_fifty,
  output logic [8:0] key_level
);

  localparam int                NCH     = 9;
  localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   r_s1;
  logic [NCH-1:0]   r_s2;
  logic [NCH-1:0]   r_stable;
  logic [NCH-1:0]   r_pulse;
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [NCH-1:0]   w_out;

  // Per-channel synchroniser, debounce counter and rising-edge pulse.
  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement (a bounce back) clears it, so a new level
  // is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_pulse  <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= key_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < NCH; i++) begin
        r_pulse[i] <= 1'b0;
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_LAST) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
          // Pulse only when the accepted level goes 0 -> 1.
          r_pulse[i]  <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef KEY_ONEHOT_EN
  logic [NCH-1:0] r_pending;
  logic [NCH-1:0] r_out;
  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_grant;

  // A pulse arriving this cycle competes immediately with older pending
  // requests; a pulse on an already-pending channel merges into the same bit.
  always_comb begin
    w_req   = r_pending | r_pulse;
    w_grant = '0;
    if      (w_req[3]) w_grant[3] = 1'b1;  // Cancel
    else if (w_req[1]) w_grant[1] = 1'b1;  // Confirm
    else if (w_req[0]) w_grant[0] = 1'b1;  // Goods
    else if (w_req[2]) w_grant[2] = 1'b1;  // Change
    else if (w_req[8]) w_grant[8] = 1'b1;  // fifty
    else if (w_req[7]) w_grant[7] = 1'b1;  // twenty
    else if (w_req[6]) w_grant[6] = 1'b1;  // ten
    else if (w_req[5]) w_grant[5] = 1'b1;  // five
    else if (w_req[4]) w_grant[4] = 1'b1;  // one
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pending <= '0;
      r_out     <= '0;
    end else begin
      r_pending <= w_req & ~w_grant;
      r_out     <= w_grant;
    end
  end

  assign w_out = r_out;
`else
  assign w_out = r_pulse;
`endif

  assign sys_Goods       = w_out[0];
  assign sys_Confirm     = w_out[1];
  assign sys_Change      = w_out[2];
  assign sys_Cancel      = w_out[3];
  assign in_money_one    = w_out[4];
  assign in_money_five   = w_out[5];
  assign in_money_ten    = w_out[6];
  assign in_money_twenty = w_out[7];
  assign in_money_fifty  = w_out[8];
  assign key_level       = r_stable;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end input conditioner for the vending-machine controller. Takes the nine raw board buttons (four function keys and five money keys), synchronises and debounces each one, and emits one-clock-wide press pulses. These pulses drive the `sys_Goods`, `sys_Confirm`, `sys_Change`, `sys_Cancel` and `in_money_*` inputs of `state_transitions`. It sits directly between the board pins and `state_transitions`, so the controller only ever sees clean single-cycle events.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive cycles a new level must hold before it is accepted (10 ms at 100 MHz). Legal range 1..2^CNT_W−1.
- `CNT_W`, default 20: width of each per-channel debounce counter.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk`  in  1  system clock, 100 MHz; all logic on the rising edge.
- `sys_rst`  in  1  synchronous active-high reset.
- `key_raw`  in  9  asynchronous button levels, 1 = pressed. Bit map: [0] Goods, [1] Confirm, [2] Change, [3] Cancel, [4] one, [5] five, [6] ten, [7] twenty, [8] fifty.
- `sys_Goods`, `sys_Confirm`, `sys_Change`, `sys_Cancel`  out  1 each  press pulses for the function keys.
- `in_money_one`, `in_money_five`, `in_money_ten`, `in_money_twenty`, `in_money_fifty`  out  1 each  press pulses for the money keys.
- `key_level`  out  9  debounced stable level per channel, same bit map as `key_raw`.

## Operation

Each channel runs independently with the following registers:
- Synchroniser: two flops, `s1` then `s2`.
- Accepted level: `stable`.
- Debounce counter: `cnt`, CNT_W bits.

Per-cycle behaviour of each channel:
- If `s2 == stable`: `cnt <= 0`.
- If `s2 != stable` and `cnt == DEBOUNCE_CYCLES−1`: `stable <= s2` and `cnt <= 0`.
- Otherwise (`s2 != stable`): `cnt <= cnt+1`.

Pulse generation:
- The channel pulse register is set to 1 on exactly the edge where `stable` goes 0→1. It is 0 on every other cycle.
- Releases (1→0) are debounced the same way but never produce a pulse.

Boundary conditions:
- Bounce: any return of `s2` to `stable` before the count completes clears `cnt`. No pulse is produced and no partial credit is kept.
- A key held continuously produces exactly one pulse. The next pulse requires a debounced release followed by a debounced press.
- Simultaneous presses on different channels produce simultaneous pulses, unless KEY_ONEHOT_EN is defined (see Configuration).
- `cnt` never exceeds `DEBOUNCE_CYCLES−1`, so there is no wrap-around.

## Timing

- Reset value of every register and output is 0: `s1`, `s2`, `stable`, `cnt`, all pulses, `key_level`, and the pending bits.
- Reset is honoured mid-operation: the channel is cleared on the reset edge, and any count in progress or pulse about to fire is discarded.
- A key held through reset is treated as a fresh press. It yields one pulse at DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Press latency: number the rising edge that first samples the new raw level into `s1` as edge 1. The pulse register goes high at edge DEBOUNCE_CYCLES+2 and stays high for exactly one cycle.
- `key_level` rises on the same edge as the pulse.
- Release latency: `key_level` falls at edge DEBOUNCE_CYCLES+2, counted the same way.
- There are no combinational paths from `key_raw` to any output.

## Configuration

Macro: `KEY_ONEHOT_EN`.

Without the macro:
- Pulses go straight from the per-channel pulse registers to the outputs. Several outputs may be high in the same cycle.

With the macro:
- A 9-bit `pending` register sits between the pulse registers and the outputs.
- A pulse sets its channel's pending bit.
- Each cycle the single highest-priority pending bit is driven to its output (registered) and cleared.
- Priority order: Cancel > Confirm > Goods > Change > fifty > twenty > ten > five > one.
- At most one output is high per cycle.
- A new pulse on a channel whose pending bit is already set is merged, not counted twice.
- This adds one cycle of latency, so an uncontended press fires at edge DEBOUNCE_CYCLES+3.
- `key_level` timing is unchanged.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and a 10 ns clock.

- Clean press: hold `key_raw[1]` high for 20 cycles → `sys_Confirm` high for exactly one cycle at edge 6; `key_level[1]`=1 from edge 6; all other outputs 0.
- Bounce: toggle `key_raw[8]` 1,0,1,0 on successive cycles, then hold 1 → no pulse during the toggling; exactly one `in_money_fifty` pulse 6 edges after the final rising sample.
- Hold and re-press: hold `key_raw[4]` for 100 cycles, release for 10 cycles, press again → exactly two `in_money_one` pulses; `key_level[4]` falls 6 edges after the release.
- Reset mid-count: press `key_raw[3]`, assert `sys_rst` for one cycle at edge 4 while continuing to hold → no pulse before the reset; one `sys_Cancel` pulse 6 edges after the first post-reset edge; all outputs 0 during reset.
- Simultaneous, macro undefined: press `key_raw[0]` and `key_raw[5]` on the same cycle → `sys_Goods` and `in_money_five` are high on the same edge 6.
- Simultaneous, `KEY_ONEHOT_EN` defined: press `key_raw[3]`, `key_raw[0]` and `key_raw[6]` together → `sys_Cancel` at edge 7, `sys_Goods` at edge 8, `in_money_ten` at edge 9; never two outputs high in the same cycle.
